irig_decoder: RTL and testbench
===============================

# irig_decoder

IRIG-B timecode front end. Samples the IRIG-B DC-level input on a 10 MHz clock, classifies each 10 ms bit cell by its high-time as 0, 1 or position marker, and locks to the 100-bit frame. It emits a pulse-per-second (PPS) aligned to the on-time leading edge of each frame's reference marker. It sits between the IRIG-B receiver pin and the system time/PPS distribution logic.

## Interface
Parameters:
- T_MIN, 10000: minimum valid high time in cycles (1.0 ms).
- T_01, 35000: boundary between 0 and 1 (3.5 ms).
- T_1M, 65000: boundary between 1 and marker (6.5 ms).
- T_MAX, 95000: maximum valid high time (9.5 ms).
- T_TIMEOUT, 120000: maximum high or low level duration before loss of lock (12 ms).
- PPS_WIDTH, 100000: PPS high duration in cycles (10 ms).

Ports:
- clk_10mhz  in  1  10 MHz system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- irigb  in  1  IRIG-B DC-level input, asynchronous to clk_10mhz.
- pps  out  1  PPS pulse, high for PPS_WIDTH cycles at each frame start while locked.

## Operation
- irigb passes through a 2-flop synchronizer. A third register provides rising- and falling-edge detection.
- High-time counter: cleared on the synchronized rising edge, increments while high, and saturates at 2^17-1 (17 bits). A low-time counter of the same width works the same way for low levels.
- On each falling edge the high time H is classified:
  - T_MIN ≤ H < T_01 → ZERO.
  - T_01 ≤ H < T_1M → ONE.
  - T_1M ≤ H ≤ T_MAX → MARK.
  - Any other value → ERROR.
- State machine:
  - SEARCH: track the previous symbol. A MARK immediately following a MARK moves to LOCKED with bit_idx = 0, meaning the second mark is Pr.
  - LOCKED: bit_idx (7 bits) increments on every rising edge and wraps 99→0.
    - A classified symbol whose bit_idx is 0, 9, 19, …, 89 or 99 must be MARK. Any other index must be ZERO or ONE.
    - A mismatch → SEARCH.
- In any state, the following → SEARCH, clearing lock and mark history:
  - an ERROR symbol;
  - a high or low level lasting longer than T_TIMEOUT.
- PPS: in LOCKED, the rising edge on which bit_idx wraps 99→0 starts pps. pps stays high for PPS_WIDTH cycles.
  - No PPS is produced for the Pr that achieves lock. The first PPS comes one frame (1 s) later.
  - Loss of lock while pps is high does not truncate the pulse.
- Frame data bits are not decoded or exported by this block.

## Timing
- Reset: pps = 0, state = SEARCH, all counters = 0, synchronizer flops = 0.
- Latency: pps rises on the 3rd clk_10mhz rising edge after the first edge that samples irigb high. The path is 2 sync stages plus the registered output.
- Classification is resolved 2 cycles after irigb falls.
- Counter boundaries are inclusive/exclusive exactly as listed. A high time of exactly T_01 is ONE, and exactly T_MAX is MARK.
- Simultaneous events: a timeout and an edge in the same cycle → the edge is processed and the timeout is ignored.
- Reset asserted mid-pulse forces pps low immediately, asynchronously.

## Structure
- Shared package irig_pkg holds:
  - the symbol enum: ZERO, ONE, MARK, ERROR, NONE;
  - the state enum: SEARCH, LOCKED;
  - marker-index constants: 0, 9, 19 … 99.
- Sub-module irig_bit_classifier contains the synchronizer, edge detect, high/low counters, classification and timeout. Its outputs are a symbol-valid strobe, the symbol, the rising-edge strobe and the timeout flag. The top module holds the frame state machine and the PPS generator.

## Test plan
- Reset: rst=0 for 120 ns then released, irigb idle low → pps = 0, state SEARCH. The low-time timeout leaves it in SEARCH.
- Classification: bits of 2.0005 ms, 5.0005 ms and 8.0005 ms high, each in a 10 ms cell → ZERO, ONE, MARK. 0.5 ms and 9.8 ms high → ERROR.
- Lock acquisition: D0, D1, MARK, MARK, D1, D1, D0 → LOCKED after the second MARK falls, bit_idx = 3 after the last bit, pps stays 0.
- PPS generation: lock, then one full valid 100-bit frame → pps rises exactly 3 cycles after the next Pr leading edge (1.000000 s after the locking Pr) and stays high 100000 cycles.
- Loss of lock: while LOCKED, send ONE at bit_idx 9 → SEARCH and no pps at the next frame. Re-acquire on the next MARK-MARK.
- Async reset mid-PPS: assert rst 5000 cycles into a pps pulse → pps = 0 within the same cycle, state SEARCH.

Source files
------------

// File: rtl/irig_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irig_pkg
//  Description : Shared types and constants for the IRIG-B decoder: symbol
//                and state enums, counter width and the frame positions
//                that must carry a position marker.
//  Revision    : 1.0 - initial release
// ============================================================================
package irig_pkg;

    // Width of the high/low level counters (saturate at 2^17-1).
    localparam int c_CNT_W = 17;

    // Width of the frame bit index (0..99).
    localparam int c_IDX_W = 7;

    // Index of the last bit in a frame; the next rising edge is Pr again.
    localparam logic [c_IDX_W-1:0] c_LAST_BIT = 7'd99;

    typedef enum logic [2:0] {
        ZERO,
        ONE,
        MARK,
        ERROR,
        NONE
    } sym_t;

    typedef enum logic [0:0] {
        SEARCH,
        LOCKED
    } state_t;

    // Frame positions that carry a position marker: Pr, P1..P9, P0.
    localparam int c_NUM_MARKS = 11;
    localparam logic [c_IDX_W-1:0] c_MARK_IDX [c_NUM_MARKS] = '{
        7'd0,  7'd9,  7'd19, 7'd29, 7'd39, 7'd49,
        7'd59, 7'd69, 7'd79, 7'd89, 7'd99
    };

    function automatic logic is_mark_idx(input logic [c_IDX_W-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < c_NUM_MARKS; i++) begin
            if (idx == c_MARK_IDX[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage : irig_pkg
`default_nettype wire

// File: rtl/irig_bit_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irig_bit_classifier
//  Description : Synchronizes the IRIG-B level, detects edges, measures high
//                and low durations and classifies each bit cell by its high
//                time.
//  Ports       : clk_10mhz     - 10 MHz clock
//                rst           - asynchronous active-low reset
//                i_irigb       - raw IRIG-B level (asynchronous)
//                o_sym_valid   - one-cycle strobe, o_sym holds a new symbol
//                o_sym         - classified symbol (NONE when not valid)
//                o_rise        - one-cycle strobe on a synchronized rising edge
//                o_timeout     - current level has lasted beyond T_TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
module irig_bit_classifier
    import irig_pkg::*;
#(
    parameter int unsigned T_MIN     = 10000,
    parameter int unsigned T_01      = 35000,
    parameter int unsigned T_1M      = 65000,
    parameter int unsigned T_MAX     = 95000,
    parameter int unsigned T_TIMEOUT = 120000
) (
    input  logic clk_10mhz,
    input  logic rst,
    input  logic i_irigb,
    output logic o_sym_valid,
    output sym_t o_sym,
    output logic o_rise,
    output logic o_timeout
);

    localparam logic [c_CNT_W-1:0] c_T_MIN     = c_CNT_W'(T_MIN);
    localparam logic [c_CNT_W-1:0] c_T_01      = c_CNT_W'(T_01);
    localparam logic [c_CNT_W-1:0] c_T_1M      = c_CNT_W'(T_1M);
    localparam logic [c_CNT_W-1:0] c_T_MAX     = c_CNT_W'(T_MAX);
    localparam logic [c_CNT_W-1:0] c_T_TIMEOUT = c_CNT_W'(T_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = '1;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic [c_CNT_W-1:0] r_high_cnt;
    logic [c_CNT_W-1:0] r_low_cnt;
    logic               r_sym_valid;
    sym_t               r_sym;
    logic               r_rise;
    logic               r_timeout;

    logic               w_rise;
    logic               w_fall;
    logic [c_CNT_W-1:0] w_high_inc;
    logic [c_CNT_W-1:0] w_low_inc;
    sym_t               w_class;
    logic               w_level_long;

    assign w_rise = r_sync2 & ~r_sync3;
    assign w_fall = ~r_sync2 & r_sync3;

    always_comb begin
        w_high_inc = r_high_cnt;
        w_low_inc  = r_low_cnt;
        if (r_high_cnt != c_CNT_MAX) begin
            w_high_inc = r_high_cnt + 1'b1;
        end
        if (r_low_cnt != c_CNT_MAX) begin
            w_low_inc = r_low_cnt + 1'b1;
        end
    end

    // On the falling-edge cycle r_high_cnt holds the number of cycles the
    // synchronized level was high.
    always_comb begin
        w_class = ERROR;
        if ((r_high_cnt >= c_T_MIN) && (r_high_cnt < c_T_01)) begin
            w_class = ZERO;
        end else if ((r_high_cnt >= c_T_01) && (r_high_cnt < c_T_1M)) begin
            w_class = ONE;
        end else if ((r_high_cnt >= c_T_1M) && (r_high_cnt <= c_T_MAX)) begin
            w_class = MARK;
        end
    end

    assign w_level_long = r_sync2 ? (r_high_cnt > c_T_TIMEOUT)
                                  : (r_low_cnt  > c_T_TIMEOUT);

    always_ff @(posedge clk_10mhz or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_high_cnt  <= '0;
            r_low_cnt   <= '0;
            r_sym_valid <= 1'b0;
            r_sym       <= NONE;
            r_rise      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_sync1 <= i_irigb;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            // The edge cycle is itself the first cycle of the new level,
            // so each counter restarts at 1 rather than 0.
            if (w_rise) begin
                r_high_cnt <= c_CNT_W'(1);
            end else if (r_sync2) begin
                r_high_cnt <= w_high_inc;
            end

            if (w_fall) begin
                r_low_cnt <= c_CNT_W'(1);
            end else if (!r_sync2) begin
                r_low_cnt <= w_low_inc;
            end

            r_rise      <= w_rise;
            r_sym_valid <= w_fall;
            r_sym       <= w_fall ? w_class : NONE;
            // An edge wins over a timeout landing in the same cycle.
            r_timeout   <= w_level_long & ~(w_rise | w_fall);
        end
    end

    assign o_sym_valid = r_sym_valid;
    assign o_sym       = r_sym;
    assign o_rise      = r_rise;
    assign o_timeout   = r_timeout;

endmodule : irig_bit_classifier
`default_nettype wire

// File: rtl/irig_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irig_decoder
//  Description : IRIG-B front end. Locks to the 100-bit frame using the
//                classified symbol stream and emits a PPS pulse on the
//                leading edge of each frame reference marker while locked.
//  Ports       : clk_10mhz - 10 MHz clock
//                rst       - asynchronous active-low reset
//                irigb     - IRIG-B DC-level input (asynchronous)
//                pps       - high for PPS_WIDTH cycles at each frame start
//  Revision    : 1.0 - initial release
// ============================================================================
module irig_decoder
    import irig_pkg::*;
#(
    parameter int unsigned T_MIN     = 10000,
    parameter int unsigned T_01      = 35000,
    parameter int unsigned T_1M      = 65000,
    parameter int unsigned T_MAX     = 95000,
    parameter int unsigned T_TIMEOUT = 120000,
    parameter int unsigned PPS_WIDTH = 100000
) (
    input  logic clk_10mhz,
    input  logic rst,
    input  logic irigb,
    output logic pps
);

    localparam int                 c_PPS_W    = $clog2(PPS_WIDTH + 1);
    localparam logic [c_PPS_W-1:0] c_PPS_LAST = c_PPS_W'(PPS_WIDTH - 1);

    logic               w_sym_valid;
    sym_t               w_sym;
    logic               w_rise;
    logic               w_timeout;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prev_mark;
    logic               w_prev_mark_nxt;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic [c_IDX_W-1:0] w_bit_idx_nxt;
    logic               w_pps_start;
    logic               r_pps;
    logic [c_PPS_W-1:0] r_pps_cnt;

    irig_bit_classifier #(
        .T_MIN     (T_MIN),
        .T_01      (T_01),
        .T_1M      (T_1M),
        .T_MAX     (T_MAX),
        .T_TIMEOUT (T_TIMEOUT)
    ) u_classifier (
        .clk_10mhz   (clk_10mhz),
        .rst         (rst),
        .i_irigb     (irigb),
        .o_sym_valid (w_sym_valid),
        .o_sym       (w_sym),
        .o_rise      (w_rise),
        .o_timeout   (w_timeout)
    );

    always_ff @(posedge clk_10mhz or negedge rst) begin
        if (!rst) begin
            r_state     <= SEARCH;
            r_prev_mark <= 1'b0;
            r_bit_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_mark <= w_prev_mark_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
        end
    end

    // Lock is declared on the falling edge of the second of two adjacent
    // marks, so that mark is Pr (index 0) and the next rising edge starts
    // bit 1. The PPS therefore first fires one full frame after locking.
    always_comb begin
        w_state_nxt     = r_state;
        w_prev_mark_nxt = r_prev_mark;
        w_bit_idx_nxt   = r_bit_idx;
        w_pps_start     = 1'b0;

        if (w_timeout) begin
            w_state_nxt     = SEARCH;
            w_prev_mark_nxt = 1'b0;
            w_bit_idx_nxt   = '0;
        end else begin
            case (r_state)
                SEARCH: begin
                    if (w_sym_valid) begin
                        if ((w_sym == MARK) && r_prev_mark) begin
                            w_state_nxt     = LOCKED;
                            w_bit_idx_nxt   = '0;
                            w_prev_mark_nxt = 1'b0;
                        end else begin
                            w_prev_mark_nxt = (w_sym == MARK);
                        end
                    end
                end
                LOCKED: begin
                    if (w_rise) begin
                        if (r_bit_idx == c_LAST_BIT) begin
                            w_bit_idx_nxt = '0;
                            w_pps_start   = 1'b1;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + 7'd1;
                        end
                    end
                    // The symbol belongs to the bit opened by the previous
                    // rising edge, i.e. the current r_bit_idx.
                    if (w_sym_valid) begin
                        if (w_sym == ERROR) begin
                            w_state_nxt     = SEARCH;
                            w_prev_mark_nxt = 1'b0;
                        end else if ((w_sym == MARK) != is_mark_idx(r_bit_idx)) begin
                            w_state_nxt     = SEARCH;
                            w_prev_mark_nxt = (w_sym == MARK);
                        end
                    end
                end
                default: begin
                    w_state_nxt     = SEARCH;
                    w_prev_mark_nxt = 1'b0;
                end
            endcase
        end
    end

    // The pulse runs to completion independently of lock state; only reset
    // can cut it short.
    always_ff @(posedge clk_10mhz or negedge rst) begin
        if (!rst) begin
            r_pps     <= 1'b0;
            r_pps_cnt <= '0;
        end else if (w_pps_start) begin
            r_pps     <= 1'b1;
            r_pps_cnt <= c_PPS_LAST;
        end else if (r_pps) begin
            if (r_pps_cnt == '0) begin
                r_pps <= 1'b0;
            end else begin
                r_pps_cnt <= r_pps_cnt - 1'b1;
            end
        end
    end

    assign pps = r_pps;

endmodule : irig_decoder
`default_nettype wire

// File: tb/tb_irig_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_irig_decoder
//  Description : Self-checking bench for irig_decoder with time constants
//                scaled down (50-cycle bit cells) to keep frames short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irig_decoder;
    import irig_pkg::*;

    localparam int T_MIN     = 5;
    localparam int T_01      = 17;
    localparam int T_1M      = 32;
    localparam int T_MAX     = 47;
    localparam int T_TIMEOUT = 60;
    localparam int PPS_WIDTH = 50;

    localparam int CELL   = 50;
    localparam int H_ZERO = 10;
    localparam int H_ONE  = 25;
    localparam int H_MARK = 40;

    logic clk_10mhz = 1'b0;
    logic rst       = 1'b0;
    logic irigb     = 1'b0;
    logic pps;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_lead_edge = 0;
    sym_t exp_q[$];

    int   pps_run        = 0;
    int   pps_pulses     = 0;
    int   pps_last_width = 0;
    int   pps_rise_cyc   = 0;

    irig_decoder #(
        .T_MIN     (T_MIN),
        .T_01      (T_01),
        .T_1M      (T_1M),
        .T_MAX     (T_MAX),
        .T_TIMEOUT (T_TIMEOUT),
        .PPS_WIDTH (PPS_WIDTH)
    ) dut (
        .clk_10mhz (clk_10mhz),
        .rst       (rst),
        .irigb     (irigb),
        .pps       (pps)
    );

    always #50 clk_10mhz = ~clk_10mhz;

    always @(posedge clk_10mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic sym_t model_sym(input int h);
        if (h < T_MIN || h > T_MAX) return ERROR;
        if (h < T_01) return ZERO;
        if (h < T_1M) return ONE;
        return MARK;
    endfunction

    // Called on a falling clock edge; one full cell of CELL cycles.
    task automatic send_bit(input int high);
        exp_q.push_back(model_sym(high));
        last_lead_edge = cyc + 1;
        irigb = 1'b1;
        repeat (high) @(negedge clk_10mhz);
        irigb = 1'b0;
        repeat (CELL - high) @(negedge clk_10mhz);
    endtask

    task automatic send_frame_bits(input int first, input int last, input int bad_idx);
        for (int i = first; i <= last; i++) begin
            if (i == bad_idx)        send_bit(H_ONE);
            else if (i % 10 == 9)    send_bit(H_MARK);
            else                     send_bit((i % 2 == 1) ? H_ONE : H_ZERO);
        end
    endtask

    // Scoreboard: every classified symbol must match the oldest pending one.
    always @(negedge clk_10mhz) begin
        if (dut.w_sym_valid) begin
            check("sym_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("sym", 32'(dut.w_sym), 32'(exp_q.pop_front()));
        end
    end

    always @(negedge clk_10mhz) begin
        if (pps) begin
            if (pps_run == 0) pps_rise_cyc = cyc;
            pps_run++;
        end else if (pps_run != 0) begin
            pps_pulses++;
            pps_last_width = pps_run;
            pps_run = 0;
        end
    end

    initial begin
        int cls_h [14];
        int lock_pr_edge;
        int pr_edge;
        int pulses_before;

        cls_h = '{H_ZERO, H_ONE, H_MARK, 2, 49, T_MIN, T_MIN - 1, T_01, T_01 - 1,
                  T_1M, T_1M - 1, T_MAX, T_MAX + 1, H_ZERO};

        // Reset and idle
        rst   = 1'b0;
        irigb = 1'b0;
        #120 rst = 1'b1;
        @(negedge clk_10mhz);
        check("rst_pps", pps, 0);
        check("rst_state", 32'(dut.r_state), 32'(SEARCH));
        check("rst_bit_idx", 32'(dut.r_bit_idx), 0);
        repeat (T_TIMEOUT + 20) @(negedge clk_10mhz);
        check("idle_timeout", dut.w_timeout, 1);
        check("idle_state", 32'(dut.r_state), 32'(SEARCH));
        check("idle_pps", pps, 0);

        // Classification, including every boundary
        foreach (cls_h[i]) send_bit(cls_h[i]);
        check("cls_state", 32'(dut.r_state), 32'(SEARCH));
        check("cls_drain", 32'(exp_q.size()), 0);

        // Lock acquisition: D0 D1 M M D1 D1 D0
        send_bit(H_ZERO);
        send_bit(H_ONE);
        send_bit(H_MARK);
        send_bit(H_MARK);
        lock_pr_edge = last_lead_edge;
        check("lock_state", 32'(dut.r_state), 32'(LOCKED));
        check("lock_idx0", 32'(dut.r_bit_idx), 0);
        send_bit(H_ONE);
        send_bit(H_ONE);
        send_bit(H_ZERO);
        check("lock_idx3", 32'(dut.r_bit_idx), 3);
        check("lock_pps", pps, 0);
        check("lock_no_pulse", 32'(pps_pulses), 0);

        // Rest of the frame, then Pr -> PPS
        send_frame_bits(4, 99, -1);
        check("frame_state", 32'(dut.r_state), 32'(LOCKED));
        pulses_before = pps_pulses;
        send_bit(H_MARK);
        pr_edge = last_lead_edge;
        send_frame_bits(1, 2, -1);
        check("pps_count", 32'(pps_pulses), 32'(pulses_before + 1));
        check("pps_width", 32'(pps_last_width), 32'(PPS_WIDTH));
        check("pps_latency", 32'(pps_rise_cyc - pr_edge), 3);
        check("pps_one_frame", 32'(pps_rise_cyc - lock_pr_edge), 32'(100 * CELL + 3));

        // Loss of lock: ONE in the P1 slot
        send_frame_bits(3, 9, 9);
        check("loss_state", 32'(dut.r_state), 32'(SEARCH));
        send_frame_bits(10, 99, -1);
        pulses_before = pps_pulses;
        send_bit(H_MARK);
        check("relock_state", 32'(dut.r_state), 32'(LOCKED));
        check("relock_idx", 32'(dut.r_bit_idx), 0);
        send_frame_bits(1, 5, -1);
        check("relock_no_pps", 32'(pps_pulses), 32'(pulses_before));
        check("relock_idx5", 32'(dut.r_bit_idx), 5);

        // Async reset in the middle of a PPS pulse
        send_frame_bits(6, 99, -1);
        check("arst_drain", 32'(exp_q.size()), 0);
        irigb = 1'b1;
        for (int i = 0; i < 10 && !pps; i++) @(negedge clk_10mhz);
        check("arst_pps_up", pps, 1);
        repeat (PPS_WIDTH / 2) @(negedge clk_10mhz);
        check("arst_pps_mid", pps, 1);
        @(posedge clk_10mhz);
        #10 rst = 1'b0;
        #1;
        check("arst_pps", pps, 0);
        check("arst_state", 32'(dut.r_state), 32'(SEARCH));
        irigb = 1'b0;
        #300 rst = 1'b1;
        repeat (5) @(negedge clk_10mhz);
        check("arst_pps_after", pps, 0);
        check("arst_state_after", 32'(dut.r_state), 32'(SEARCH));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_irig_decoder
`default_nettype wire
